// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and the count-width helper for the FIFO family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int c_DEF_DATAWIDTH     = 8;
    localparam int c_DEF_ADDRWIDTH     = 9;
    localparam int c_AFULL_MARGIN      = 4;
    localparam int c_DEF_AEMPTY_THRESH = 3;

    // Pointers and counts carry one extra bit so full and empty are distinct.
    function automatic int cnt_width(input int addrwidth);
        return addrwidth + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port RAM, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_we,
    input  logic [ADDRWIDTH-1:0] i_waddr,
    input  logic [DATAWIDTH-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [ADDRWIDTH-1:0] i_raddr,
    output logic [DATAWIDTH-1:0] o_rdata
);

    logic [DATAWIDTH-1:0] r_mem [0:(1<<ADDRWIDTH)-1];
    logic [DATAWIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with programmable almost flags, occupancy
//               count and overflow/underflow pulses. Define FIFO_FWFT_EN for
//               first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH     = c_DEF_DATAWIDTH,
    parameter int ADDRWIDTH     = c_DEF_ADDRWIDTH,
    parameter int AFULL_THRESH  = (1 << ADDRWIDTH) - c_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = c_DEF_AEMPTY_THRESH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [DATAWIDTH-1:0]           data_in,
    input  logic                           rd_en,
    output logic [DATAWIDTH-1:0]           data_out,
    output logic                           f_full,
    output logic                           f_empty,
    output logic                           f_afull,
    output logic                           f_aempty,
    output logic [cnt_width(ADDRWIDTH)-1:0] data_count,
    output logic                           wr_overflow,
    output logic                           rd_underflow
);

    localparam int CW = cnt_width(ADDRWIDTH);
    localparam logic [CW-1:0] c_DEPTH  = CW'(1 << ADDRWIDTH);
    localparam logic [CW-1:0] c_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] c_AEMPTY = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    logic [CW-1:0]        r_wr_ptr, r_rd_ptr, r_count;
    logic [CW-1:0]        w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
    logic                 r_full, r_empty, r_afull, r_aempty, r_ovf, r_unf;
    logic                 w_empty_nxt;
    logic                 w_wr_acc;
    logic                 w_ram_re;
    logic [DATAWIDTH-1:0] w_ram_q;

    assign w_wr_acc = wr_en & ~r_full;

    fifo_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDRWIDTH-1:0]),
        .i_wdata (data_in),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr[ADDRWIDTH-1:0]),
        .o_rdata (w_ram_q)
    );

`ifdef FIFO_FWFT_EN
    // Two-stage prefetch: RAM read register (r_qval) then output register
    // (r_oval). Both stages count as stored words.
    logic                 r_qval, r_oval;
    logic                 w_qval_nxt, w_oval_nxt;
    logic                 w_pop, w_oload;
    logic [CW-1:0]        w_ram_cnt;
    logic [DATAWIDTH-1:0] r_dout;

    assign w_pop     = rd_en & r_oval;
    assign w_oload   = r_qval & (~r_oval | w_pop);
    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
    assign w_ram_re  = (w_ram_cnt != '0) & (~r_qval | w_oload);

    always_comb begin
        w_qval_nxt = r_qval;
        w_oval_nxt = r_oval;
        if (w_ram_re) begin
            w_qval_nxt = 1'b1;
        end else if (w_oload) begin
            w_qval_nxt = 1'b0;
        end
        if (w_oload) begin
            w_oval_nxt = 1'b1;
        end else if (w_pop) begin
            w_oval_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_qval <= 1'b0;
            r_oval <= 1'b0;
            r_dout <= '0;
        end else begin
            r_qval <= w_qval_nxt;
            r_oval <= w_oval_nxt;
            if (w_oload) begin
                r_dout <= w_ram_q;
            end
        end
    end

    assign w_rd_ptr_nxt = r_rd_ptr + (w_ram_re ? c_ONE : '0);
    assign w_wr_ptr_nxt = r_wr_ptr + (w_wr_acc ? c_ONE : '0);
    assign w_count_nxt  = (w_wr_ptr_nxt - w_rd_ptr_nxt)
                        + (w_qval_nxt ? c_ONE : '0)
                        + (w_oval_nxt ? c_ONE : '0);
    assign w_empty_nxt  = ~w_oval_nxt;
    assign data_out     = r_dout;
`else
    logic w_rd_acc;

    assign w_rd_acc     = rd_en & ~r_empty;
    assign w_ram_re     = w_rd_acc;
    assign w_rd_ptr_nxt = r_rd_ptr + (w_rd_acc ? c_ONE : '0);
    assign w_wr_ptr_nxt = r_wr_ptr + (w_wr_acc ? c_ONE : '0);
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_empty_nxt  = (w_count_nxt == '0);
    assign data_out     = w_ram_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_DEPTH);
            r_empty  <= w_empty_nxt;
            r_afull  <= (w_count_nxt >= c_AFULL);
            r_aempty <= (w_count_nxt <= c_AEMPTY);
            r_ovf    <= wr_en & r_full;
            r_unf    <= rd_en & r_empty;
        end
    end

    assign f_full       = r_full;
    assign f_empty      = r_empty;
    assign f_afull      = r_afull;
    assign f_aempty     = r_aempty;
    assign data_count   = r_count;
    assign wr_overflow  = r_ovf;
    assign rd_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Self-checking bench for sync_fifo_prog (DEPTH 16) against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_prog;

    localparam int c_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       f_full, f_empty, f_afull, f_aempty;
    logic [4:0] data_count;
    logic       wr_overflow, rd_underflow;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] q_model[$];
    logic [7:0] exp_dout = '0;

    sync_fifo_prog #(
        .DATAWIDTH     (8),
        .ADDRWIDTH     (4),
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .f_full       (f_full),
        .f_empty      (f_empty),
        .f_afull      (f_afull),
        .f_aempty     (f_aempty),
        .data_count   (data_count),
        .wr_overflow  (wr_overflow),
        .rd_underflow (rd_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},  32'(f_empty),    32'd1);
        check({tag, "_aempty"}, 32'(f_aempty),   32'd1);
        check({tag, "_full"},   32'(f_full),     32'd0);
        check({tag, "_afull"},  32'(f_afull),    32'd0);
        check({tag, "_count"},  32'(data_count), 32'd0);
        check({tag, "_dout"},   32'(data_out),   32'd0);
    endtask

`ifndef FIFO_FWFT_EN
    // One clock of stimulus; the model applies the FIFO rules on the
    // pre-edge occupancy, then every output is compared after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic was_full, was_empty, exp_ovf, exp_unf;
        int   sz;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        was_full  = (q_model.size() == c_DEPTH);
        was_empty = (q_model.size() == 0);
        exp_ovf   = w && was_full;
        exp_unf   = r && was_empty;
        if (r && !was_empty) exp_dout = q_model.pop_front();
        if (w && !was_full)  q_model.push_back(d);
        sz = q_model.size();
        #1;
        check("count",  32'(data_count),   32'(sz));
        check("full",   32'(f_full),       32'(sz == c_DEPTH));
        check("empty",  32'(f_empty),      32'(sz == 0));
        check("afull",  32'(f_afull),      32'(sz >= 12));
        check("aempty", 32'(f_aempty),     32'(sz <= 3));
        check("dout",   32'(data_out),     32'(exp_dout));
        check("ovf",    32'(wr_overflow),  32'(exp_ovf));
        check("unf",    32'(rd_underflow), 32'(exp_unf));
        @(negedge clk);
    endtask
`endif

    initial begin
        #13;
        check_reset_state("rst0");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

`ifdef FIFO_FWFT_EN
        wr_en   = 1'b1;
        data_in = 8'h5A;
        @(posedge clk); #1;
        check("fw_cnt_e0",   32'(data_count), 32'd1);
        check("fw_empty_e0", 32'(f_empty),    32'd1);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk); #1;
        check("fw_empty_e1", 32'(f_empty),    32'd1);
        @(posedge clk); #1;
        check("fw_empty_e2", 32'(f_empty),    32'd0);
        check("fw_dout_e2",  32'(data_out),   32'h5A);
        check("fw_cnt_e2",   32'(data_count), 32'd1);
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk); #1;
        check("fw_empty_pop", 32'(f_empty),    32'd1);
        check("fw_cnt_pop",   32'(data_count), 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            data_in = 8'(8'h30 + i);
            q_model.push_back(data_in);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("fw_cnt5", 32'(data_count), 32'd5);
        while (q_model.size() != 0) begin
            exp_dout = q_model.pop_front();
            check("fw_head_valid", 32'(f_empty),  32'd0);
            check("fw_head",       32'(data_out), 32'(exp_dout));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("fw_drained", 32'(f_empty), 32'd1);
`else
        // Fill 0x00..0x0F, overflow with 0xAA, then drain.
        for (int i = 0; i < c_DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < c_DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        // Underflow, then simultaneous access while empty.
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h77);
        // Refill, then sustained simultaneous access across the wrap.
        for (int i = 0; i < 2 * c_DEPTH && q_model.size() < c_DEPTH; i++)
            step(1'b1, 1'b0, 8'(8'h40 + i));
        check("refill_full", 32'(f_full), 32'd1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
        // Random traffic, first write-biased then read-biased.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = (i < 300) ? 70 : 30;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                 8'($urandom));
        end
        while (q_model.size() < 8) step(1'b1, 1'b0, 8'($urandom));
`endif

        // Asynchronous reset asserted mid-cycle with words stored.
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("rst_mid");
        q_model.delete();
        exp_dout = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
